// File: rtl/seq_pkg.sv
// Shared types and constants for the 1011 pattern generator and tracker.
package seq_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } fsm_state_t;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10,
    S101
  } trk_state_t;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/seq1011_track.sv
// Mealy detector for overlapping 1011 on a qualified serial bit stream.
// state | meaning
// S0    | no useful prefix seen
// S1    | last bit was 1
// S10   | last bits were 10
// S101  | last bits were 101; a 1 now completes a match
module seq1011_track
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_en,
  output logic hit
);

  trk_state_t st_q, st_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S0;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    hit  = 1'b0;
    if (clr) begin
      st_d = S0;
    end else if (bit_en) begin
      case (st_q)
        S0:   st_d = bit_in ? S1 : S0;
        S1:   st_d = bit_in ? S1 : S10;
        S10:  st_d = bit_in ? S101 : S0;
        S101: begin
          // A completed match leaves a trailing 1, so matches can overlap.
          if (bit_in == SEQ_1011[0]) begin
            hit  = 1'b1;
            st_d = S1;
          end else begin
            st_d = S10;
          end
        end
        default: st_d = S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with optional back-to-back repeat
// and a saturating count of 1011 matches emitted.
// state | meaning
// IDLE  | waiting for a pattern load; pat_ready high
// SHIFT | emitting one pattern bit per cycle
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic             repeat_en,
  input  logic             stop,
  output logic             xout,
  output logic             xout_valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       hit_cnt
);

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(1);

  fsm_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] eff_len;
  logic             xout_d, xout_valid_d, pat_ready_d, busy_d, done_d;
  logic [7:0]       hit_cnt_d;
  logic             load, bit_en, hit;

  assign eff_len = ((pat_len == '0) || (pat_len > LEN_FULL)) ? LEN_FULL : pat_len;
  assign load    = pat_valid && pat_ready;
  assign bit_en  = (state_q == SHIFT);

  seq1011_track u_track (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .bit_in (xout),
    .bit_en (bit_en),
    .hit    (hit)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    reload_d  = reload_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    done_d    = 1'b0;
    hit_cnt_d = hit_cnt;

    if (load) begin
      hit_cnt_d = '0;
    end else if (hit && (hit_cnt != 8'hFF)) begin
      hit_cnt_d = hit_cnt + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d  = pat_data;
          reload_d = pat_data;
          cnt_d    = eff_len;
          len_d    = eff_len;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // stop beats both the reload and the done pulse on the last bit
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          if (repeat_en) begin
            shreg_d = reload_q;
            cnt_d   = len_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_LAST;
        end
      end
      default: state_d = IDLE;
    endcase

    xout_valid_d = (state_d == SHIFT);
    busy_d       = (state_d == SHIFT);
    pat_ready_d  = (state_d == IDLE);
    xout_d       = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      reload_q   <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      xout       <= 1'b0;
      xout_valid <= 1'b0;
      pat_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      xout       <= xout_d;
      xout_valid <= xout_valid_d;
      pat_ready  <= pat_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      hit_cnt    <= hit_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: expected serial bits are queued at load
// time and popped by a monitor on every valid cycle.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pat_data = '0;
  logic [3:0] pat_len = '0;
  logic       pat_valid = 1'b0;
  logic       pat_ready;
  logic       repeat_en = 1'b0;
  logic       stop = 1'b0;
  logic       xout, xout_valid, busy, done;
  logic [7:0] hit_cnt;

  int   tests = 0;
  int   fails = 0;
  int   vcount = 0;
  int   dcount = 0;
  int   n;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pat_data   (pat_data),
    .pat_len    (pat_len),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .repeat_en  (repeat_en),
    .stop       (stop),
    .xout       (xout),
    .xout_valid (xout_valid),
    .busy       (busy),
    .done       (done),
    .hit_cnt    (hit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) dcount++;
    if (rst_n && xout_valid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        check("xout_unexpected_bit", 32'(xout_valid), 32'(0));
      end else begin
        check("xout_bit", 32'(xout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic load(input logic [7:0] d, input logic [3:0] len, input logic rep,
                      input int passes);
    int l;
    int t;
    l = ((len == 0) || (len > 8)) ? 8 : int'(len);
    t = 0;
    while (!pat_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("load_ready", 32'(pat_ready), 32'(1));
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < l; i++) exp_q.push_back(d[7-i]);
    pat_data  = d;
    pat_len   = len;
    repeat_en = rep;
    pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < budget);
    check("done_seen", 32'(done), 32'(1));
  endtask

  task automatic end_of_pass(input string tag, input int n_got, input int n_exp,
                             input int bits, input int hits);
    check({tag, "_cycles"}, 32'(n_got), 32'(n_exp));
    check({tag, "_valid_cnt"}, 32'(vcount), 32'(bits));
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(hits));
    check({tag, "_ready"}, 32'(pat_ready), 32'(1));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'(0));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'(0));
    check({tag, "_done_cnt"}, 32'(dcount), 32'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(pat_ready), 32'(1));
    check("rst_valid", 32'(xout_valid), 32'(0));
    check("rst_xout", 32'(xout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_hits", 32'(hit_cnt), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single full pass
    vcount = 0; dcount = 0;
    load(8'b1011_1011, 4'd8, 1'b0, 1);
    wait_done(30, n);
    end_of_pass("full", n, 9, 8, 2);

    // short length with an overlapping second match
    vcount = 0; dcount = 0;
    load(8'b1011_0110, 4'd7, 1'b0, 1);
    wait_done(30, n);
    end_of_pass("len7", n, 8, 7, 2);

    // repeat; drop repeat_en during the third pass
    vcount = 0; dcount = 0;
    load(8'b1011_0000, 4'd4, 1'b1, 3);
    repeat (8) @(posedge clk);
    #1 repeat_en = 1'b0;
    wait_done(30, n);
    end_of_pass("repeat", n, 5, 12, 3);

    // length 0 means full width; a mid-pass load request is dropped
    vcount = 0; dcount = 0;
    load(8'b1100_1010, 4'd0, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1 begin pat_data = 8'hFF; pat_len = 4'd2; pat_valid = 1'b1; end
    @(posedge clk); #1 pat_valid = 1'b0;
    wait_done(30, n);
    end_of_pass("len0", n, 5, 8, 0);
    repeat (3) @(negedge clk);
    check("len0_no_reload", 32'(vcount), 32'(8));

    // length 1 and an over-range length
    vcount = 0; dcount = 0;
    load(8'h80, 4'd1, 1'b0, 1);
    wait_done(10, n);
    end_of_pass("len1", n, 2, 1, 0);
    vcount = 0; dcount = 0;
    load(8'b1011_1011, 4'd12, 1'b0, 1);
    wait_done(30, n);
    end_of_pass("len12", n, 9, 8, 2);

    // abort on bit 3: that bit is still counted
    vcount = 0; dcount = 0;
    load(8'b1011_1011, 4'd8, 1'b0, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(i != 1);
    repeat (3) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check("stop_valid", 32'(xout_valid), 32'(0));
    check("stop_ready", 32'(pat_ready), 32'(1));
    check("stop_done", 32'(done), 32'(0));
    check("stop_hits", 32'(hit_cnt), 32'(1));
    check("stop_bits", 32'(vcount), 32'(4));
    check("stop_queue_left", 32'(exp_q.size()), 32'(0));
    stop = 1'b1;
    repeat (3) @(negedge clk);
    stop = 1'b0;
    check("stop_idle_ready", 32'(pat_ready), 32'(1));
    check("stop_idle_hits", 32'(hit_cnt), 32'(1));
    check("stop_no_done", 32'(dcount), 32'(0));

    // asynchronous reset mid-pass
    vcount = 0; dcount = 0;
    load(8'b1011_1011, 4'd8, 1'b0, 1);
    repeat (5) @(posedge clk);
    #1 check("midrst_hits_before", 32'(hit_cnt), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", 32'(xout_valid), 32'(0));
    check("midrst_xout", 32'(xout), 32'(0));
    check("midrst_ready", 32'(pat_ready), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_hits", 32'(hit_cnt), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_valid", 32'(xout_valid), 32'(0));
    check("postrst_ready", 32'(pat_ready), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
